send_frame_mul_arb: RTL and testbench
=====================================

SEND_FRAME_MUL_ARB -- requirements
Module: send_frame_mul_arb

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters; MUL_STAGES, default 2, multiplier pipeline depth (1..4); A_WIDTH, default 17; B_WIDTH, default 17; P_WIDTH, default 32.
REQ-002 ap_clk  in  1  sole clock, all state on rising edge.
REQ-003 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-005 req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-006 req_a  in  NUM_REQ*A_WIDTH  packed operand A, requester i at bits [i*A_WIDTH +: A_WIDTH].
REQ-007 req_b  in  NUM_REQ*B_WIDTH  packed operand B, same packing.
REQ-008 rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle; no backpressure.
REQ-009 rsp_p  out  P_WIDTH  shared product bus, valid only while rsp_valid is non-zero.
REQ-010 stat_grant_cnt  out  NUM_REQ*16  packed per-requester grant counters (see Configuration).

Function
REQ-011 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, wraps modulo NUM_REQ, and grants the first asserted req_valid.
REQ-012 req_ready SHALL be combinational from req_valid and rr_ptr, at most one bit high, all zero when no request is pending.
REQ-013 After a transfer by requester g, rr_ptr SHALL become (g+1) mod NUM_REQ; with no transfer, rr_ptr SHALL hold.
REQ-014 Throughput SHALL be one multiply issued per cycle, with no bubble between back-to-back grants.
REQ-015 Product SHALL be unsigned A*B truncated to the low P_WIDTH bits.
REQ-016 Latency SHALL be exactly MUL_STAGES cycles from transfer edge to rsp_valid high, with rsp_valid[g] returned to the granted requester via a tag pipeline of the same depth.
REQ-017 Results SHALL retire in issue order; each transfer SHALL produce exactly one rsp_valid pulse.
REQ-018 A requester holding req_valid SHALL be granted within NUM_REQ cycles (starvation-free).
REQ-019 When no transfer occurs, rsp_p SHALL retain its last value and rsp_valid SHALL be zero MUL_STAGES cycles later.

Reset
REQ-020 On ap_rst_n low, regardless of clock: rr_ptr=0, all pipeline valid/tag bits=0, rsp_valid=0, rsp_p=0, stat_grant_cnt=0.
REQ-021 Reset mid-operation SHALL discard in-flight products, with no rsp_valid pulse for them after release.
REQ-022 req_ready SHALL be zero while ap_rst_n is low.

Configuration
REQ-023 With SEND_FRAME_MUL_ARB_STATS_EN defined, each 16-bit counter SHALL increment on its requester's transfer and saturate at 0xFFFF.
REQ-024 Without SEND_FRAME_MUL_ARB_STATS_EN, stat_grant_cnt SHALL be tied to zero and no counter flops SHALL be inferred.

Structure
REQ-025 Package send_frame_mul_pkg SHALL hold default width constants (17/17/32) and the MUL_STAGES default.
REQ-026 Sub-module send_frame_mul_pipe SHALL contain the registered multiply plus valid/tag shift chain; the arbiter and counters stay in the top.

Verification
REQ-027 Single request: req0 a=3 b=5, NUM_REQ=4, MUL_STAGES=2 -> req_ready[0] same cycle; rsp_valid=0001, rsp_p=15 exactly 2 cycles later.
REQ-028 All four valid continuously from reset -> grants 0,1,2,3,0 on consecutive cycles; one rsp per cycle in the same order.
REQ-029 Max operands a=b=0x1FFFF -> rsp_p=0xFFFC0001.
REQ-030 Grant to req2, then only req1 and req3 valid -> req3 granted next, then req1.
REQ-031 Assert ap_rst_n low with 2 products in flight -> rsp_valid stays 0 after release; rr_ptr=0.
REQ-032 STATS_EN build, 70000 grants to req0 -> counter reads 0xFFFF; non-STATS build -> 0.

Source files
------------

// File: rtl/send_frame_mul_pkg.sv
// Shared defaults and helpers for the round-robin multiply arbiter.
package send_frame_mul_pkg;

  localparam int unsigned A_WIDTH_DEF    = 17;
  localparam int unsigned B_WIDTH_DEF    = 17;
  localparam int unsigned P_WIDTH_DEF    = 32;
  localparam int unsigned MUL_STAGES_DEF = 2;
  localparam int unsigned CNT_WIDTH      = 16;

  // Saturating increment for the grant statistics counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/send_frame_mul_pipe.sv
// Registered unsigned multiply with a one-hot tag chain of equal depth.
module send_frame_mul_pipe
  import send_frame_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MUL_STAGES = MUL_STAGES_DEF,
  parameter int unsigned A_WIDTH    = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH    = B_WIDTH_DEF,
  parameter int unsigned P_WIDTH    = P_WIDTH_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic [B_WIDTH-1:0] i_b,
  input  logic [NUM_REQ-1:0] i_tag,
  output logic [NUM_REQ-1:0] o_tag,
  output logic [P_WIDTH-1:0] o_prod
);

  logic [P_WIDTH-1:0] w_prod;
  logic [NUM_REQ-1:0] r_tag  [MUL_STAGES];
  logic [P_WIDTH-1:0] r_prod [MUL_STAGES];

  // Low P_WIDTH bits of a product depend only on the low P_WIDTH bits of each operand.
  assign w_prod = P_WIDTH'(i_a) * P_WIDTH'(i_b);

  // Product stages load only with a live tag so the output holds its last result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned s = 0; s < MUL_STAGES; s++) begin
        r_tag[s]  <= '0;
        r_prod[s] <= '0;
      end
    end else begin
      r_tag[0] <= i_tag;
      if (|i_tag) r_prod[0] <= w_prod;
      for (int unsigned s = 1; s < MUL_STAGES; s++) begin
        r_tag[s] <= r_tag[s-1];
        if (|r_tag[s-1]) r_prod[s] <= r_prod[s-1];
      end
    end
  end

  assign o_tag  = r_tag[MUL_STAGES-1];
  assign o_prod = r_prod[MUL_STAGES-1];

endmodule

// File: rtl/send_frame_mul_arb.sv
// Round-robin arbiter feeding a shared pipelined multiplier.
// Optional per-requester grant counters: define SEND_FRAME_MUL_ARB_STATS_EN.
module send_frame_mul_arb
  import send_frame_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MUL_STAGES = MUL_STAGES_DEF,
  parameter int unsigned A_WIDTH    = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH    = B_WIDTH_DEF,
  parameter int unsigned P_WIDTH    = P_WIDTH_DEF
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [P_WIDTH-1:0]           rsp_p,
  output logic [NUM_REQ*CNT_WIDTH-1:0] stat_grant_cnt
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [NUM_REQ-1:0] w_rot_req;
  logic [NUM_REQ-1:0] w_rot_oh;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_xfer;
  logic [A_WIDTH-1:0] w_a;
  logic [B_WIDTH-1:0] w_b;
  logic               w_hit;

  // Rotate requests so the search always starts at bit 0, then rotate the grant back.
  assign w_rot_req = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);

  always_comb begin
    w_rot_oh = '0;
    w_hit    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_rot_req[i] && !w_hit) begin
        w_rot_oh[i] = 1'b1;
        w_hit       = 1'b1;
      end
    end
  end

  assign w_gnt     = NUM_REQ'(({w_rot_oh, w_rot_oh} << r_rr_ptr) >> NUM_REQ)
                     & {NUM_REQ{ap_rst_n}};
  assign req_ready = w_gnt;
  assign w_xfer    = req_valid & w_gnt;

  // Operand select and pointer advance for the single granted requester.
  always_comb begin
    w_a        = '0;
    w_b        = '0;
    w_next_ptr = r_rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_xfer[i]) begin
        w_a        = req_a[i*A_WIDTH +: A_WIDTH];
        w_b        = req_b[i*B_WIDTH +: B_WIDTH];
        w_next_ptr = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_rr_ptr <= '0;
    else           r_rr_ptr <= w_next_ptr;
  end

  send_frame_mul_pipe #(
    .NUM_REQ    (NUM_REQ),
    .MUL_STAGES (MUL_STAGES),
    .A_WIDTH    (A_WIDTH),
    .B_WIDTH    (B_WIDTH),
    .P_WIDTH    (P_WIDTH)
  ) u_pipe (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_a     (w_a),
    .i_b     (w_b),
    .i_tag   (w_xfer),
    .o_tag   (rsp_valid),
    .o_prod  (rsp_p)
  );

`ifdef SEND_FRAME_MUL_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] r_cnt [NUM_REQ];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_xfer[i]) r_cnt[i] <= sat_inc(r_cnt[i]);
      end
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      stat_grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt[i];
    end
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_send_frame_mul_arb.sv
// Directed bench with a cycle-level round-robin/multiply reference model.
module tb_send_frame_mul_arb;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int AW = 17;
  localparam int BW = 17;
  localparam int PW = 32;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [PW-1:0]   rsp_p;
  logic [N*16-1:0] stat_grant_cnt;

  always #5 ap_clk = ~ap_clk;

  send_frame_mul_arb #(
    .NUM_REQ(N), .MUL_STAGES(S), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .rsp_valid      (rsp_valid),
    .rsp_p          (rsp_p),
    .stat_grant_cnt (stat_grant_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int              m_ptr = 0;
  logic [PW-1:0]   m_last_p = '0;
  logic [N-1:0]    m_exp_v [int];
  logic [PW-1:0]   m_exp_p [int];
  int unsigned     m_cnt [N];
  int              m_cyc = 0;
  int              m_g;
  logic [N-1:0]    m_ev;
  logic [63:0]     m_prod;
  logic [N*16-1:0] m_stat;

  // Every falling edge: predict ready/rsp/stat from the model, compare, then advance the model.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_p", 64'(rsp_p), 64'd0);
      check("rst_stat", 64'(stat_grant_cnt), 64'd0);
      m_ptr = 0;
      m_last_p = '0;
      m_exp_v.delete();
      m_exp_p.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      m_g = -1;
      for (int k = 0; k < N; k++) begin
        if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
      end
      check("ready", 64'(req_ready), (m_g < 0) ? 64'd0 : (64'd1 << m_g));
      m_ev = '0;
      if (m_exp_v.exists(m_cyc)) begin
        m_ev     = m_exp_v[m_cyc];
        m_last_p = m_exp_p[m_cyc];
        m_exp_v.delete(m_cyc);
        m_exp_p.delete(m_cyc);
      end
      check("rsp_valid", 64'(rsp_valid), 64'(m_ev));
      check("rsp_p", 64'(rsp_p), 64'(m_last_p));
      m_stat = '0;
`ifdef SEND_FRAME_MUL_ARB_STATS_EN
      for (int i = 0; i < N; i++)
        m_stat[i*16 +: 16] = (m_cnt[i] > 65535) ? 16'hFFFF : 16'(m_cnt[i]);
`endif
      check("stat", 64'(stat_grant_cnt), 64'(m_stat));
      if (m_g >= 0) begin
        m_prod = 64'(req_a[m_g*AW +: AW]) * 64'(req_b[m_g*BW +: BW]);
        m_exp_v[m_cyc + S] = N'(1) << m_g;
        m_exp_p[m_cyc + S] = m_prod[PW-1:0];
        m_ptr = (m_g + 1) % N;
        m_cnt[m_g]++;
      end
    end
    m_cyc++;
  end

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  logic [N-1:0]  gl [6];
  logic [PW-1:0] pl [6];

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    ap_rst_n  = 1'b0;
    gl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    pl = '{32'd10, 32'd40, 32'd90, 32'd160, 32'd10, 32'd40};
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;

    // Single request, latency two cycles
    set_op(0, 17'd3, 17'd5);
    req_valid = 4'b0001;
    #1 check("single_ready", 64'(req_ready), 64'h1);
    next_cycle();
    req_valid = '0;
    next_cycle();
    check("single_rsp_valid", 64'(rsp_valid), 64'h1);
    check("single_rsp_p", 64'(rsp_p), 64'd15);
    next_cycle();
    check("single_one_pulse", 64'(rsp_valid), 64'h0);
    check("single_p_hold", 64'(rsp_p), 64'd15);

    // All four valid from reset: back-to-back round robin
    ap_rst_n = 1'b0;
    repeat (2) next_cycle();
    ap_rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, AW'(i + 1), BW'(10 * (i + 1)));
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 6) ? 4'hF : 4'h0;
      #1;
      if (k < 6) check($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(gl[k]));
      if (k >= 2) begin
        check($sformatf("rr_rsp_valid%0d", k - 2), 64'(rsp_valid), 64'(gl[k-2]));
        check($sformatf("rr_rsp_p%0d", k - 2), 64'(rsp_p), 64'(pl[k-2]));
      end
      next_cycle();
    end

    // Maximum operands, pointer now at 2
    set_op(1, 17'h1FFFF, 17'h1FFFF);
    req_valid = 4'b0010;
    #1 check("max_ready", 64'(req_ready), 64'h2);
    next_cycle();
    req_valid = '0;
    next_cycle();
    check("max_rsp_valid", 64'(rsp_valid), 64'h2);
    check("max_rsp_p", 64'(rsp_p), 64'hFFFC0001);

    // Grant req2, then req1/req3 contend: req3 first, then req1
    next_cycle();
    req_valid = 4'b0100;
    #1 check("wrap_g2", 64'(req_ready), 64'h4);
    next_cycle();
    req_valid = 4'b1010;
    #1 check("wrap_g3", 64'(req_ready), 64'h8);
    next_cycle();
    #1 check("wrap_g1", 64'(req_ready), 64'h2);
    next_cycle();
    req_valid = '0;
    repeat (3) next_cycle();

    // Reset with two products in flight
    req_valid = 4'b0001;
    next_cycle();
    req_valid = 4'b0100;
    next_cycle();
    req_valid = '0;
    ap_rst_n  = 1'b0;
    #1 check("rst_ready_async", 64'(req_ready), 64'h0);
    repeat (2) next_cycle();
    ap_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("flush_rsp%0d", k), 64'(rsp_valid), 64'h0);
      next_cycle();
    end
    req_valid = 4'hF;
    #1 check("ptr_after_rst", 64'(req_ready), 64'h1);
    next_cycle();

    // Counter saturation on req0
    req_valid = 4'b0001;
    repeat (70000) @(posedge ap_clk);
    #1 req_valid = '0;
    next_cycle();
`ifdef SEND_FRAME_MUL_ARB_STATS_EN
    check("stat_sat", 64'(stat_grant_cnt[15:0]), 64'hFFFF);
`else
    check("stat_tied", 64'(stat_grant_cnt), 64'h0);
`endif
    repeat (3) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
